alu_exec: RTL and testbench
===========================

# alu_exec

Multi-cycle execute unit that consumes the 4-bit `alucontrol` code produced by the ALU decoder and performs the selected operation. It sits in the execute stage of the multi-cycle datapath. Logic/arithmetic ops complete in one cycle; shifts are iterative, STEP bits per cycle, to save area. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `STEP`, 1: bits shifted per cycle in SHIFT state; legal values 1, 2, 4, 8, 16.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `alucontrol` in 4: operation code, see Operation.
- `a` in WIDTH: operand A (rs).
- `b` in WIDTH: operand B (rt / immediate).
- `shamt` in 5: shift amount for sll/srl/sra.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: operation result.
- `zero` out 1: result==0; for blez, (signed a <= 0).
- `illegal` out 1: unsupported code; qualified by out_valid.

## Operation
- States: IDLE, SHIFT, DONE.
- Codes: 0000 and; 0001 or; 0010 add; 0110 sub; 0111 slt (signed, result 1/0); 1001 xor; 1000 lui (b<<16); 1010 blez (result=a, zero=signed a<=0); 0011 sll; 1100 srl; 1011 srlv; 1101 sra.
- Shift operand is b. The shift amount n is shamt for sll/srl/sra and a[4:0] for srlv.
- Other codes: result=0, zero=1, illegal=1, single-cycle.
- Add/sub wrap modulo 2^32. There is no overflow flag.
- IDLE: on in_valid&&in_ready, latch the op, operands and n.
  - Shift op with n>0: go to SHIFT.
  - Otherwise: compute the result and go to DONE.
- SHIFT: each cycle shift by min(STEP, remaining) and decrement remaining. When remaining reaches 0, go to DONE.
  - srl fills with 0. sra fills with the sign bit. sll fills with 0.
- DONE: out_valid=1. result, zero and illegal are held stable until out_valid&&out_ready, then go to IDLE.
- in_valid while busy is ignored (in_ready=0). The requester must hold it.
- zero is evaluated on the final result. For blez, zero follows the blez rule instead.

## Timing
- Reset (async assert, sync-safe deassert) gives: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0.
- Accept at edge k:
  - Non-shift op, or shift with n=0: out_valid high after edge k+1.
  - Shift with n>0: out_valid high after edge k+1+ceil(n/STEP).
- Handshake at edge m in DONE: out_valid low and in_ready high after edge m.
- Earliest next accept is edge m+1. Throughput is at most one op per 2 cycles.
- Stall: out_ready low holds DONE indefinitely, with outputs unchanged.
- reset_n low mid-SHIFT or mid-DONE aborts the op immediately. The result is discarded.
- No combinational path from in_valid/alucontrol/a/b to result. All result outputs are registered.

## Structure
- Shared package `alu_pkg`:
  - alucontrol code constants (also used by the ALU decoder).
  - `alu_state_t` enum {IDLE, SHIFT, DONE}.
  - `is_shift()` helper.
- Natural sub-module: `alu_shift_step`. It is a combinational one-step shifter with inputs value, amount (≤STEP) and kind (sll/srl/sra), and it is instantiated once.
- Counter: 5-bit remaining amount.

## Test plan
- add a=0x7FFFFFFF, b=1 -> after 1 cycle: result=0x80000000, zero=0. sub a=5, b=5 -> result=0, zero=1.
- slt a=0xFFFFFFFF (-1), b=1 -> result=1. lui b=0x00001234 -> result=0x12340000.
- sra b=0x80000000, shamt=31, STEP=1 -> out_valid 32 cycles after accept, result=0xFFFFFFFF. srl, same inputs -> result=0x00000001.
- srlv a=4, b=0xF0 -> result=0x0F, latency 5 cycles. sll shamt=0 -> latency 1, result=b.
- blez a=0 -> zero=1. blez a=1 -> zero=0. Code 1111 -> illegal=1, result=0.
- out_ready held low 10 cycles: result stable, in_ready=0, new in_valid ignored. reset_n pulsed mid-SHIFT -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states
// and helpers that classify an operation code.
package alu_pkg;

    // alucontrol codes, shared with the ALU decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_BLEZ = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_t;

    // True for the operations that run through the iterative shifter
    function automatic logic is_shift(input logic [3:0] op);
        logic res;
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRLV, ALU_SRA: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

    // Fill rule used by the one-step shifter for a given operation
    function automatic shift_kind_t shift_kind(input logic [3:0] op);
        shift_kind_t res;
        case (op)
            ALU_SLL:           res = SK_SLL;
            ALU_SRL, ALU_SRLV: res = SK_SRL;
            ALU_SRA:           res = SK_SRA;
            default:           res = SK_SLL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter. The caller limits amount to at most STEP
// bits, so one instance serves every cycle of an iterative shift.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic [4:0]       amount,
    input  shift_kind_t      kind,
    output logic [WIDTH-1:0] result
);

    // Shift value by amount with zero or sign fill depending on kind
    always_comb begin
        result = value;
        case (kind)
            SK_SLL:  result = value << amount;
            SK_SRL:  result = value >> amount;
            SK_SRA:  result = $unsigned($signed(value) >>> amount);
            default: result = value;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute unit. An accepted op is latched in IDLE; the following
// cycle(s) are spent in SHIFT, which first walks the remaining shift amount
// down STEP bits per cycle (zero cycles for non-shift ops or n=0) and, once
// nothing remains, registers result/zero/illegal and moves to DONE. The
// result is held in DONE until the consumer takes it.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    alu_state_t       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] val_q, val_d;     // operand b, shifted in place for shift ops
    logic [4:0]       rem_q, rem_d;     // shift bits still to apply
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [4:0]       n_s;
    logic [4:0]       amt_s;
    shift_kind_t      kind_s;
    logic [WIDTH-1:0] step_out_s;
    logic [WIDTH-1:0] calc_result_s;
    logic             calc_zero_s;
    logic             calc_illegal_s;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Shift amount of the incoming op: register-sourced for srlv, shamt otherwise
    always_comb begin
        if (alucontrol == ALU_SRLV) begin
            n_s = a[4:0];
        end else begin
            n_s = shamt;
        end
    end

    // Bits to shift this cycle: min(STEP, remaining)
    always_comb begin
        kind_s = shift_kind(op_q);
        if (rem_q < STEP_AMT) begin
            amt_s = rem_q;
        end else begin
            amt_s = STEP_AMT;
        end
    end

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .value  (val_q),
        .amount (amt_s),
        .kind   (kind_s),
        .result (step_out_s)
    );

    // Final result of the latched op; shift ops have already been applied to val_q
    always_comb begin
        calc_result_s  = '0;
        calc_illegal_s = 1'b0;
        case (op_q)
            ALU_AND:  calc_result_s = a_q & val_q;
            ALU_OR:   calc_result_s = a_q | val_q;
            ALU_ADD:  calc_result_s = a_q + val_q;
            ALU_SUB:  calc_result_s = a_q - val_q;
            ALU_SLT:  calc_result_s = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(val_q))};
            ALU_XOR:  calc_result_s = a_q ^ val_q;
            ALU_LUI:  calc_result_s = val_q << 16;
            ALU_BLEZ: calc_result_s = a_q;
            ALU_SLL, ALU_SRL, ALU_SRLV, ALU_SRA: calc_result_s = val_q;
            default: begin
                calc_result_s  = '0;
                calc_illegal_s = 1'b1;
            end
        endcase
        if (op_q == ALU_BLEZ) begin
            calc_zero_s = a_q[WIDTH-1] | (a_q == '0);
        end else begin
            calc_zero_s = (calc_result_s == '0);
        end
    end

    // Next-state logic: accept, iterate the shift, then hold until taken
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        val_d     = val_q;
        rem_d     = rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = alucontrol;
                    a_d   = a;
                    val_d = b;
                    if (is_shift(alucontrol)) begin
                        rem_d = n_s;
                    end else begin
                        rem_d = 5'd0;
                    end
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (rem_q == 5'd0) begin
                    result_d  = calc_result_s;
                    zero_d    = calc_zero_s;
                    illegal_d = calc_illegal_s;
                    state_d   = DONE;
                end else begin
                    val_d   = step_out_s;
                    rem_d   = rem_q - amt_s;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= 4'b0000;
            a_q       <= '0;
            val_q     <= '0;
            rem_q     <= 5'd0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            val_q     <= val_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed ops, a reference model computing
// result/zero/illegal/latency from the operation rules, and one compare
// process checking the handshake and outputs every cycle an op is in flight.
module tb_alu_exec;

    localparam int TB_STEP = 1;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec #(
        .WIDTH (32),
        .STEP  (TB_STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        zr;
        logic        ill;
        int          lat;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t cur;
    exp_t m;
    int   e_cnt;
    bit   pending  = 1'b0;
    bit   post_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Reference model: what the unit must produce, from the operation rules
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] av,
                                   input logic [31:0] bv, input logic [4:0] sh);
        exp_t r;
        int n;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = av;
        sb = bv;
        n = 0;
        r.ill = 1'b0;
        case (op)
            4'b0000: r.res = av & bv;
            4'b0001: r.res = av | bv;
            4'b0010: r.res = av + bv;
            4'b0110: r.res = av - bv;
            4'b0111: r.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1001: r.res = av ^ bv;
            4'b1000: r.res = bv * 32'd65536;
            4'b1010: r.res = av;
            4'b0011: begin n = int'(sh);      r.res = bv << n; end
            4'b1100: begin n = int'(sh);      r.res = bv >> n; end
            4'b1011: begin n = int'(av % 32); r.res = bv >> n; end
            4'b1101: begin n = int'(sh);      r.res = 32'(sb >>> n); end
            default: begin r.res = 32'd0; r.ill = 1'b1; end
        endcase
        if (op == 4'b1010) r.zr = (sa <= 0);
        else               r.zr = (r.res == 32'd0);
        r.lat = 1 + (n + TB_STEP - 1) / TB_STEP;
        return r;
    endfunction

    // Compare process: handshake timing and held outputs while an op is in flight
    initial begin
        forever begin
            @(negedge clk);
            if (post_chk) begin
                chk("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
                chk("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);
                post_chk = 1'b0;
            end
            if (pending) begin
                chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
                chk("out_valid_timing", {31'd0, out_valid}, {31'd0, (e_cnt >= cur.lat)});
                if (out_valid) begin
                    chk("result", result, cur.res);
                    chk("zero", {31'd0, zero}, {31'd0, cur.zr});
                    chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
                end
                e_cnt++;
            end
        end
    end

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue one op, optionally stall the consumer, then take the result
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] sh, input int stall);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) begin
            chk("wait_in_ready_timeout", 32'd0, 32'd1);
            pulse_reset();
        end
        in_valid = 1'b1; alucontrol = op; a = av; b = bv; shamt = sh;
        @(posedge clk);
        #1;
        cur = model(op, av, bv, sh);
        e_cnt = 0;
        pending = 1'b1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h0BADF00D; shamt = 5'd7; alucontrol = 4'b0010;
        t = 0;
        while (!out_valid && t < cur.lat + 5) begin @(negedge clk); t++; end
        if (!out_valid) begin
            pending = 1'b0;
            chk("out_valid_timeout", 32'd0, 32'd1);
            pulse_reset();
        end else begin
            if (stall > 0) begin
                in_valid = 1'b1; alucontrol = 4'b1111;
                repeat (stall) @(negedge clk);
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            pending = 1'b0;
            post_chk = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = 4'b0000; a = 32'd0; b = 32'd0; shamt = 5'd0;

        // Pin the model against hand-computed values
        m = model(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0);
        chk("pin_add", m.res, 32'h80000000);
        chk("pin_add_lat", m.lat, 32'd1);
        m = model(4'b1101, 32'd0, 32'h80000000, 5'd31);
        chk("pin_sra", m.res, 32'hFFFFFFFF);
        chk("pin_sra_lat", m.lat, 32'd32);
        m = model(4'b1011, 32'd4, 32'h000000F0, 5'd0);
        chk("pin_srlv", m.res, 32'h0000000F);
        chk("pin_srlv_lat", m.lat, 32'd5);
        m = model(4'b1010, 32'hFFFFFFFE, 32'd0, 5'd0);
        chk("pin_blez_neg", {31'd0, m.zr}, 32'd1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);   // add wrap into sign
        run_op(4'b0110, 32'd5, 32'd5, 5'd0, 0);                 // sub -> zero
        run_op(4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 0);          // add wraps to 0
        run_op(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 0);          // slt signed
        run_op(4'b0111, 32'd1, 32'hFFFFFFFF, 5'd0, 0);          // slt false
        run_op(4'b1000, 32'd0, 32'h00001234, 5'd0, 0);          // lui
        run_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0);   // and
        run_op(4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 0);   // or
        run_op(4'b1001, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 0);   // xor
        run_op(4'b1101, 32'd0, 32'h80000000, 5'd31, 0);         // sra 31
        run_op(4'b1100, 32'd0, 32'h80000000, 5'd31, 0);         // srl 31
        run_op(4'b1011, 32'd4, 32'h000000F0, 5'd3, 0);          // srlv by a
        run_op(4'b0011, 32'd0, 32'h12345678, 5'd0, 0);          // sll by 0
        run_op(4'b0011, 32'd0, 32'h80000001, 5'd3, 0);          // sll drops top bit
        run_op(4'b1010, 32'd0, 32'd9, 5'd0, 0);                 // blez 0
        run_op(4'b1010, 32'd1, 32'd0, 5'd0, 0);                 // blez 1
        run_op(4'b1010, 32'h80000000, 32'd0, 5'd0, 0);          // blez negative
        run_op(4'b1111, 32'd3, 32'd4, 5'd0, 0);                 // illegal
        run_op(4'b0100, 32'd3, 32'd4, 5'd0, 0);                 // illegal
        run_op(4'b0010, 32'd3, 32'd4, 5'd0, 10);                // consumer stall

        // Reset in the middle of a long shift
        in_valid = 1'b1; alucontrol = 4'b1101; a = 32'd0; b = 32'h80000000; shamt = 5'd31;
        @(posedge clk);
        #1;
        cur = model(4'b1101, 32'd0, 32'h80000000, 5'd31);
        e_cnt = 0;
        pending = 1'b1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        pending = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(4'b0110, 32'd10, 32'd3, 5'd0, 0);                // recovery after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
